debug_access_ctrl: RTL and testbench
====================================

Name: debug_access_ctrl

Overview:
- Gated front end for the 256x8 debug register bank. It shares the bank between two requesters: port A (external debug host) and port B (on-chip monitor).
- Port A accesses are refused until a key unlock succeeds. Repeated key failures force a timed lockout.
- Sits between the debug transport and the register bank. It is the only block that drives bank enable and write enable.

Parameters:
- ADDR_W, 8, bank address width
- DATA_W, 8, bank data width
- UNLOCK_KEY, 32'hA5C3_5A3C, key value that unlocks port A
- MAX_FAIL, 3, consecutive bad keys before lockout (1..7)
- LOCKOUT_CYCLES, 1024, lockout duration in clk cycles (>=2)
- IDLE_RELOCK, 65535, idle cycles after which UNLOCKED returns to LOCKED

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- a_req  in  1  port A access request (level, held until a_ack)
- a_we  in  1  port A write=1, read=0
- a_addr  in  ADDR_W  port A address
- a_wdata  in  DATA_W  port A write data
- a_ack  out  1  port A one-cycle completion pulse
- a_err  out  1  port A access refused (valid with a_ack)
- a_rdata  out  DATA_W  port A read data (valid with a_ack, !a_err)
- b_req, b_we, b_addr, b_wdata  in  same widths as port A  port B request
- b_ack, b_rdata  out  1 / DATA_W  port B completion and read data
- key_valid  in  1  one-cycle strobe carrying key_data
- key_data  in  32  candidate key
- bank_en  out  1  bank access strobe
- bank_we  out  1  bank write enable
- bank_addr  out  ADDR_W  bank address
- bank_wdata  out  DATA_W  bank write data
- bank_rdata  in  DATA_W  bank read data, valid 1 cycle after bank_en
- sec_state  out  2  00=LOCKED, 01=UNLOCKED, 10=LOCKOUT

Behaviour:
- Reset:
  - Security FSM goes to LOCKED; fail count=0; timers=0.
  - All ack, err and bank_* outputs are 0; rdata outputs are 0; arbiter priority points to B.
- Security FSM:
  - LOCKED, key_valid with a match: go to UNLOCKED, clear fail count.
  - LOCKED, key_valid with a mismatch: increment fail count. When the count reaches MAX_FAIL, go to LOCKOUT, load the timer with LOCKOUT_CYCLES-1, clear fail count.
  - LOCKOUT: key_valid is ignored and does not count. The timer decrements each cycle; at 0, go to LOCKED.
  - UNLOCKED: the idle counter increments every cycle with no granted port A access and clears on each grant. On reaching IDLE_RELOCK, go to LOCKED. key_valid with a mismatch also goes to LOCKED (no fail count). key_valid with a match has no effect.
- Access sequencer (IDLE, ISSUE, RESP):
  - IDLE: arbitrate among pending requests, then go to ISSUE.
  - ISSUE: drive bank_en=1, with bank_we, bank_addr and bank_wdata from the winner.
  - RESP: capture bank_rdata, pulse the winner's ack for one cycle, return to IDLE.
  - Request-to-ack latency is 3 cycles when uncontended.
  - Requests sampled in IDLE are held by the requester; address and data are registered at grant.
- Port A while not UNLOCKED:
  - Granted normally, but ISSUE drives bank_en=0. RESP gives a_ack=1, a_err=1, a_rdata=0.
  - The bank is never touched.
- Arbitration:
  - Round-robin; the port just served drops to lowest priority.
  - Simultaneous A and B requests after reset: B wins first, then A.
  - Port B ignores security state; b has no err output.
- Simultaneous events:
  - key_valid during an in-flight A access: the state used for the access is the one latched at grant.
  - A relock mid-transaction does not abort the access.
- Reset mid-transaction:
  - The sequencer goes to IDLE; no ack is issued; bank_en drops in the same cycle reset is sampled.
- Width rules:
  - Fail count is 3 bits and saturates at MAX_FAIL.
  - Timers are $clog2(max(LOCKOUT_CYCLES, IDLE_RELOCK)+1) bits and do not wrap.

Decomposition:
- Package dbg_ctrl_pkg holds:
  - the sec_state enum (LOCKED, UNLOCKED, LOCKOUT);
  - the sequencer state enum (IDLE, ISSUE, RESP);
  - the default UNLOCK_KEY constant.
- One sub-module, dbg_rr_arb2: two-input round-robin arbiter with priority update on grant.
- Security FSM and sequencer stay in the top module.

Test Plan:
- Reset, then a_req read addr 8'h10 with no key -> a_ack 3 cycles later with a_err=1, a_rdata=0; bank_en stays 0 throughout.
- key_valid with 32'hA5C3_5A3C, then a write of 8'h5A to 8'h20, then a read of 8'h20 -> sec_state=01; write ack with err=0; read a_rdata=8'h5A; exactly one bank_en pulse per access.
- Three bad keys (32'h0) from LOCKED -> sec_state=10 on the cycle after the third strobe. A correct key during lockout is ignored. After 1024 cycles sec_state=00; then a correct key -> 01.
- a_req and b_req asserted together and held (unlocked) -> acks ordered B, A, B, A; each ack spaced 3 cycles apart; no overlapping bank_en.
- Unlocked, with IDLE_RELOCK reduced to 16 and no A traffic -> sec_state returns to 00 after 16 cycles; the next A read gets a_err=1.
- rst asserted during ISSUE of a B write -> no b_ack; bank_en=0 the next cycle; sec_state=00; after rst release a new B read completes normally.

Source files
------------

// File: rtl/dbg_ctrl_pkg.sv
// rtl/dbg_ctrl_pkg.sv - shared types and constants for the debug access controller
//   sec_state_e : security FSM encoding, also the sec_state port encoding
//   seq_state_e : access sequencer states
//   DEF_UNLOCK_KEY, FAIL_W, max2() : defaults and width helpers
package dbg_ctrl_pkg;

  typedef enum logic [1:0] {
    SEC_LOCKED   = 2'b00,
    SEC_UNLOCKED = 2'b01,
    SEC_LOCKOUT  = 2'b10
  } sec_state_e;

  typedef enum logic [1:0] {
    SEQ_IDLE  = 2'b00,
    SEQ_ISSUE = 2'b01,
    SEQ_RESP  = 2'b10
  } seq_state_e;

  localparam logic [31:0] DEF_UNLOCK_KEY = 32'hA5C3_5A3C;
  localparam int          FAIL_W         = 3;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/dbg_rr_arb2.sv
// rtl/dbg_rr_arb2.sv - two-input round-robin arbiter, priority moves on grant
//   clk, rst : clock, synchronous active-high reset
//   i_req[0] : port A request, i_req[1] : port B request
//   i_upd    : grant is being taken this cycle; update priority
//   o_gnt    : one-hot grant (combinational)
module dbg_rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] i_req,
  input  logic       i_upd,
  output logic [1:0] o_gnt
);

  // 1: port B wins a tie, 0: port A wins a tie
  logic r_prio_b;

  always_comb begin
    o_gnt = i_req;
    if (i_req == 2'b11) begin
      o_gnt = r_prio_b ? 2'b10 : 2'b01;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prio_b <= 1'b1;
    end else if (i_upd && (o_gnt != 2'b00)) begin
      // serving A hands the tie to B, serving B hands it to A
      r_prio_b <= o_gnt[0];
    end
  end

endmodule

// File: rtl/debug_access_ctrl.sv
// rtl/debug_access_ctrl.sv - key-gated, two-port arbitrated front end of the debug register bank
//   clk, rst                         : clock, synchronous active-high reset
//   a_req/a_we/a_addr/a_wdata        : port A (debug host) request, held until a_ack
//   a_ack/a_err/a_rdata              : port A completion pulse, refusal flag, read data
//   b_req/b_we/b_addr/b_wdata        : port B (monitor) request, held until b_ack
//   b_ack/b_rdata                    : port B completion pulse, read data
//   key_valid/key_data               : unlock key strobe
//   bank_en/bank_we/bank_addr/bank_wdata/bank_rdata : register bank interface
//   sec_state                        : 00 locked, 01 unlocked, 10 lockout
module debug_access_ctrl
  import dbg_ctrl_pkg::*;
#(
  parameter int          ADDR_W         = 8,
  parameter int          DATA_W         = 8,
  parameter logic [31:0] UNLOCK_KEY     = DEF_UNLOCK_KEY,
  parameter int          MAX_FAIL       = 3,
  parameter int          LOCKOUT_CYCLES = 1024,
  parameter int          IDLE_RELOCK    = 65535
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_ack,
  output logic              a_err,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_ack,
  output logic [DATA_W-1:0] b_rdata,
  input  logic              key_valid,
  input  logic [31:0]       key_data,
  output logic              bank_en,
  output logic              bank_we,
  output logic [ADDR_W-1:0] bank_addr,
  output logic [DATA_W-1:0] bank_wdata,
  input  logic [DATA_W-1:0] bank_rdata,
  output logic [1:0]        sec_state
);

  localparam int TMR_W = $clog2(max2(LOCKOUT_CYCLES, IDLE_RELOCK) + 1);

  localparam logic [TMR_W-1:0]  TMR_ZERO  = '0;
  localparam logic [TMR_W-1:0]  TMR_ONE   = TMR_W'(1);
  localparam logic [TMR_W-1:0]  LOCK_LOAD = TMR_W'(LOCKOUT_CYCLES - 1);
  localparam logic [TMR_W-1:0]  IDLE_LAST = TMR_W'(IDLE_RELOCK - 1);
  localparam logic [FAIL_W-1:0] FAIL_MAX  = FAIL_W'(MAX_FAIL);
  localparam logic [FAIL_W-1:0] FAIL_ONE  = FAIL_W'(1);

  // security FSM state
  sec_state_e        r_sec,      w_sec_nxt;
  logic [FAIL_W-1:0] r_fail,     w_fail_nxt;
  logic [TMR_W-1:0]  r_lock_tmr, w_lock_nxt;
  logic [TMR_W-1:0]  r_idle_cnt, w_idle_nxt;
  logic              w_key_ok;
  logic [FAIL_W-1:0] w_fail_inc;

  // sequencer state
  seq_state_e        r_seq, w_seq_nxt;
  logic [1:0]        w_req;
  logic [1:0]        w_gnt;
  logic              w_grant;
  logic              w_grant_a;
  logic              r_srv_b;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_a_ok;
  logic              r_a_ack;
  logic              r_a_err;
  logic [DATA_W-1:0] r_a_rdata;
  logic              r_b_ack;
  logic [DATA_W-1:0] r_b_rdata;
  logic              w_bank_en;
  logic              w_bank_we;
  logic [ADDR_W-1:0] w_bank_addr;
  logic [DATA_W-1:0] w_bank_wdata;

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  // A requester keeps req high during its ack cycle; masking it there stops the
  // sequencer (back in IDLE that cycle) from granting the same access twice.
  assign w_req = {b_req & ~r_b_ack, a_req & ~r_a_ack};

  dbg_rr_arb2 u_arb (
    .clk   (clk),
    .rst   (rst),
    .i_req (w_req),
    .i_upd (r_seq == SEQ_IDLE),
    .o_gnt (w_gnt)
  );

  assign w_grant   = (r_seq == SEQ_IDLE) && (w_gnt != 2'b00);
  assign w_grant_a = w_grant && w_gnt[0];

  // ---------------------------------------------------------------------------
  // Security FSM
  // ---------------------------------------------------------------------------
  assign w_key_ok   = (key_data == UNLOCK_KEY);
  assign w_fail_inc = (r_fail >= FAIL_MAX) ? FAIL_MAX : (r_fail + FAIL_ONE);

  always_comb begin
    w_sec_nxt  = r_sec;
    w_fail_nxt = r_fail;
    w_lock_nxt = r_lock_tmr;
    w_idle_nxt = r_idle_cnt;
    case (r_sec)
      SEC_LOCKED: begin
        w_idle_nxt = TMR_ZERO;
        if (key_valid) begin
          if (w_key_ok) begin
            w_sec_nxt  = SEC_UNLOCKED;
            w_fail_nxt = '0;
          end else if (w_fail_inc == FAIL_MAX) begin
            w_sec_nxt  = SEC_LOCKOUT;
            w_lock_nxt = LOCK_LOAD;
            w_fail_nxt = '0;
          end else begin
            w_fail_nxt = w_fail_inc;
          end
        end
      end
      SEC_UNLOCKED: begin
        if (key_valid && !w_key_ok) begin
          w_sec_nxt  = SEC_LOCKED;
          w_idle_nxt = TMR_ZERO;
        end else if (w_grant_a) begin
          w_idle_nxt = TMR_ZERO;
        end else if (r_idle_cnt >= IDLE_LAST) begin
          // this cycle's increment reaches the relock threshold
          w_sec_nxt  = SEC_LOCKED;
          w_idle_nxt = TMR_ZERO;
        end else begin
          w_idle_nxt = r_idle_cnt + TMR_ONE;
        end
      end
      SEC_LOCKOUT: begin
        // keys are ignored here and never reach the fail counter
        if (r_lock_tmr == TMR_ZERO) begin
          w_sec_nxt = SEC_LOCKED;
        end else begin
          w_lock_nxt = r_lock_tmr - TMR_ONE;
        end
      end
      default: begin
        w_sec_nxt  = SEC_LOCKED;
        w_fail_nxt = '0;
        w_lock_nxt = TMR_ZERO;
        w_idle_nxt = TMR_ZERO;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sec      <= SEC_LOCKED;
      r_fail     <= '0;
      r_lock_tmr <= TMR_ZERO;
      r_idle_cnt <= TMR_ZERO;
    end else begin
      r_sec      <= w_sec_nxt;
      r_fail     <= w_fail_nxt;
      r_lock_tmr <= w_lock_nxt;
      r_idle_cnt <= w_idle_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Access sequencer
  // ---------------------------------------------------------------------------
  always_comb begin
    w_seq_nxt    = r_seq;
    w_bank_en    = 1'b0;
    w_bank_we    = 1'b0;
    w_bank_addr  = '0;
    w_bank_wdata = '0;
    case (r_seq)
      SEQ_IDLE: begin
        if (w_grant) begin
          w_seq_nxt = SEQ_ISSUE;
        end
      end
      SEQ_ISSUE: begin
        // a refused port A access walks the same states but never enables the bank
        if (r_srv_b || r_a_ok) begin
          w_bank_en    = 1'b1;
          w_bank_we    = r_we;
          w_bank_addr  = r_addr;
          w_bank_wdata = r_wdata;
        end
        w_seq_nxt = SEQ_RESP;
      end
      SEQ_RESP: begin
        w_seq_nxt = SEQ_IDLE;
      end
      default: begin
        w_seq_nxt = SEQ_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_seq     <= SEQ_IDLE;
      r_srv_b   <= 1'b0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_a_ok    <= 1'b0;
      r_a_ack   <= 1'b0;
      r_a_err   <= 1'b0;
      r_a_rdata <= '0;
      r_b_ack   <= 1'b0;
      r_b_rdata <= '0;
    end else begin
      r_seq <= w_seq_nxt;
      if (w_grant) begin
        r_srv_b <= w_gnt[1];
        r_we    <= w_gnt[1] ? b_we    : a_we;
        r_addr  <= w_gnt[1] ? b_addr  : a_addr;
        r_wdata <= w_gnt[1] ? b_wdata : a_wdata;
        // security decision is frozen here so key/relock events cannot
        // change an access already in flight
        r_a_ok  <= (r_sec == SEC_UNLOCKED);
      end
      r_a_ack <= (r_seq == SEQ_RESP) && !r_srv_b;
      r_a_err <= (r_seq == SEQ_RESP) && !r_srv_b && !r_a_ok;
      r_b_ack <= (r_seq == SEQ_RESP) && r_srv_b;
      if ((r_seq == SEQ_RESP) && !r_srv_b) begin
        r_a_rdata <= r_a_ok ? bank_rdata : '0;
      end
      if ((r_seq == SEQ_RESP) && r_srv_b) begin
        r_b_rdata <= bank_rdata;
      end
    end
  end

  assign a_ack      = r_a_ack;
  assign a_err      = r_a_err;
  assign a_rdata    = r_a_rdata;
  assign b_ack      = r_b_ack;
  assign b_rdata    = r_b_rdata;
  assign bank_en    = w_bank_en;
  assign bank_we    = w_bank_we;
  assign bank_addr  = w_bank_addr;
  assign bank_wdata = w_bank_wdata;
  assign sec_state  = r_sec;

endmodule

// File: tb/tb_debug_access_ctrl.sv
// tb/tb_debug_access_ctrl.sv - directed scoreboard bench for debug_access_ctrl
module tb_debug_access_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_req, a_we;
  logic [7:0]  a_addr, a_wdata;
  logic        a_ack, a_err;
  logic [7:0]  a_rdata;
  logic        b_req, b_we;
  logic [7:0]  b_addr, b_wdata;
  logic        b_ack;
  logic [7:0]  b_rdata;
  logic        key_valid;
  logic [31:0] key_data;
  logic        bank_en, bank_we;
  logic [7:0]  bank_addr, bank_wdata;
  logic [7:0]  bank_rdata;
  logic [1:0]  sec_state;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    bit         port_b;
    bit         err;
    logic [7:0] rdata;
    bit         chk_rdata;
  } exp_t;

  exp_t exp_q[$];

  debug_access_ctrl #(
    .IDLE_RELOCK(16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .a_req      (a_req),
    .a_we       (a_we),
    .a_addr     (a_addr),
    .a_wdata    (a_wdata),
    .a_ack      (a_ack),
    .a_err      (a_err),
    .a_rdata    (a_rdata),
    .b_req      (b_req),
    .b_we       (b_we),
    .b_addr     (b_addr),
    .b_wdata    (b_wdata),
    .b_ack      (b_ack),
    .b_rdata    (b_rdata),
    .key_valid  (key_valid),
    .key_data   (key_data),
    .bank_en    (bank_en),
    .bank_we    (bank_we),
    .bank_addr  (bank_addr),
    .bank_wdata (bank_wdata),
    .bank_rdata (bank_rdata),
    .sec_state  (sec_state)
  );

  always #5 clk = ~clk;

  // register bank model: read data one cycle after bank_en
  logic [7:0] mem [256];
  int en_cnt  = 0;
  int ovl_cnt = 0;
  bit prev_en = 1'b0;

  always @(posedge clk) begin
    if (bank_en) begin
      if (bank_we) mem[bank_addr] <= bank_wdata;
      bank_rdata <= mem[bank_addr];
      en_cnt <= en_cnt + 1;
    end
    if (bank_en && prev_en) ovl_cnt <= ovl_cnt + 1;
    prev_en <= bank_en;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input bit pb, input bit err, input logic [7:0] rd, input bit chk);
    exp_t e;
    e.port_b    = pb;
    e.err       = err;
    e.rdata     = rd;
    e.chk_rdata = chk;
    exp_q.push_back(e);
  endtask

  task automatic score(input string tag);
    exp_t e;
    checks++;
    assert (exp_q.size() > 0) else begin
      failures++;
      $error("FAIL %s_sb observed=unexpected_ack expected=queued_entry", tag);
    end
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({tag, "_port"}, 32'(b_ack), 32'(e.port_b));
      if (!e.port_b) check({tag, "_err"}, 32'(a_err), 32'(e.err));
      if (e.chk_rdata) check({tag, "_rdata"}, e.port_b ? 32'(b_rdata) : 32'(a_rdata), 32'(e.rdata));
    end
  endtask

  task automatic key(input logic [31:0] k);
    key_valid = 1'b1;
    key_data  = k;
    tick();
    key_valid = 1'b0;
    key_data  = 32'h0;
  endtask

  task automatic access(input string tag, input bit pb, input bit we, input logic [7:0] addr,
                        input logic [7:0] wd, input bit exp_err, input logic [7:0] exp_rd,
                        input int exp_en);
    int n;
    int en0;
    bit got;
    push(pb, exp_err, exp_rd, !we || exp_err);
    en0 = en_cnt;
    if (pb) begin
      b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = wd;
    end else begin
      a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = wd;
    end
    n   = 0;
    got = 1'b0;
    while (!got && n < 20) begin
      tick();
      n++;
      if (a_ack || b_ack) begin
        got = 1'b1;
        score(tag);
      end
    end
    if (!got && exp_q.size() > 0) void'(exp_q.pop_front());
    check({tag, "_latency"}, 32'(n), 32'd3);
    check({tag, "_bank_en_pulses"}, 32'(en_cnt - en0), 32'(exp_en));
    a_req = 1'b0;
    b_req = 1'b0;
    tick();
  endtask

  initial begin
    int n;
    int en0;
    int ovl0;
    int nacks;
    int t_ack[4];
    int bsum;

    rst = 1'b1;
    a_req = 0; a_we = 0; a_addr = 0; a_wdata = 0;
    b_req = 0; b_we = 0; b_addr = 0; b_wdata = 0;
    key_valid = 0; key_data = 0;
    tick(); tick(); tick();

    // reset state
    check("rst_sec_state", 32'(sec_state), 32'd0);
    check("rst_a_ack", 32'(a_ack), 32'd0);
    check("rst_a_err", 32'(a_err), 32'd0);
    check("rst_b_ack", 32'(b_ack), 32'd0);
    check("rst_bank_en", 32'(bank_en), 32'd0);
    check("rst_bank_we", 32'(bank_we), 32'd0);
    check("rst_bank_addr", 32'(bank_addr), 32'd0);
    check("rst_a_rdata", 32'(a_rdata), 32'd0);
    check("rst_b_rdata", 32'(b_rdata), 32'd0);
    rst = 1'b0;

    // locked: A read refused, bank untouched
    access("locked_a_read", 1'b0, 1'b0, 8'h10, 8'h00, 1'b1, 8'h00, 0);

    // unlock, write then read back
    key(32'hA5C3_5A3C);
    check("unlock_sec_state", 32'(sec_state), 32'd1);
    access("a_write_20", 1'b0, 1'b1, 8'h20, 8'h5A, 1'b0, 8'h00, 1);
    access("a_read_20", 1'b0, 1'b0, 8'h20, 8'h00, 1'b0, 8'h5A, 1);

    // bad key while unlocked relocks without counting
    key(32'h0);
    check("bad_key_relock", 32'(sec_state), 32'd0);

    // three bad keys -> lockout
    key(32'h0);
    check("fail1_sec_state", 32'(sec_state), 32'd0);
    key(32'h0);
    check("fail2_sec_state", 32'(sec_state), 32'd0);
    key(32'h0);
    check("fail3_lockout", 32'(sec_state), 32'd2);
    key(32'hA5C3_5A3C);
    check("lockout_ignores_key", 32'(sec_state), 32'd2);
    n = 1;
    while (sec_state == 2'd2 && n < 1100) begin
      tick();
      n++;
    end
    check("lockout_duration", 32'(n), 32'd1024);
    check("lockout_exit_state", 32'(sec_state), 32'd0);
    key(32'hA5C3_5A3C);
    check("unlock_after_lockout", 32'(sec_state), 32'd1);

    // contention: B, A, B, A with 3-cycle spacing
    push(1'b1, 1'b0, 8'h00, 1'b0);
    push(1'b0, 1'b0, 8'h00, 1'b0);
    push(1'b1, 1'b0, 8'h00, 1'b0);
    push(1'b0, 1'b0, 8'h00, 1'b0);
    en0  = en_cnt;
    ovl0 = ovl_cnt;
    a_req = 1'b1; a_we = 1'b1; a_addr = 8'h40; a_wdata = 8'h11;
    b_req = 1'b1; b_we = 1'b1; b_addr = 8'h41; b_wdata = 8'h22;
    n = 0;
    nacks = 0;
    while (nacks < 4 && n < 40) begin
      tick();
      n++;
      if (a_ack && b_ack) check("contend_dual_ack", 32'd1, 32'd0);
      if (a_ack || b_ack) begin
        t_ack[nacks] = n;
        nacks++;
        score("contend");
        if (nacks == 4) begin
          a_req = 1'b0;
          b_req = 1'b0;
        end
      end
    end
    a_req = 1'b0;
    b_req = 1'b0;
    check("contend_ack_count", 32'(nacks), 32'd4);
    if (nacks == 4) begin
      check("contend_first_ack", 32'(t_ack[0]), 32'd3);
      for (int i = 1; i < 4; i++) check("contend_spacing", 32'(t_ack[i] - t_ack[i-1]), 32'd3);
    end
    check("contend_bank_en_pulses", 32'(en_cnt - en0), 32'd4);
    check("contend_bank_en_overlap", 32'(ovl_cnt - ovl0), 32'd0);
    tick();
    access("a_read_40", 1'b0, 1'b0, 8'h40, 8'h00, 1'b0, 8'h11, 1);
    access("b_read_41", 1'b1, 1'b0, 8'h41, 8'h00, 1'b0, 8'h22, 1);

    // idle relock after 16 quiet cycles
    key(32'h0);
    key(32'hA5C3_5A3C);
    check("relock_start_state", 32'(sec_state), 32'd1);
    n = 0;
    while (sec_state == 2'd1 && n < 40) begin
      tick();
      n++;
    end
    check("idle_relock_cycles", 32'(n), 32'd16);
    check("idle_relock_state", 32'(sec_state), 32'd0);
    access("relocked_a_read", 1'b0, 1'b0, 8'h20, 8'h00, 1'b1, 8'h00, 0);

    // reset during ISSUE of a B write
    key(32'hA5C3_5A3C);
    check("pre_rst_sec_state", 32'(sec_state), 32'd1);
    b_req = 1'b1; b_we = 1'b1; b_addr = 8'h50; b_wdata = 8'h77;
    tick();
    check("issue_bank_en", 32'(bank_en), 32'd1);
    check("issue_bank_we", 32'(bank_we), 32'd1);
    check("issue_bank_addr", 32'(bank_addr), 32'h50);
    check("issue_bank_wdata", 32'(bank_wdata), 32'h77);
    rst = 1'b1;
    b_req = 1'b0;
    tick();
    check("rst_mid_bank_en", 32'(bank_en), 32'd0);
    check("rst_mid_b_ack", 32'(b_ack), 32'd0);
    check("rst_mid_sec_state", 32'(sec_state), 32'd0);
    rst = 1'b0;
    bsum = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (b_ack) bsum++;
    end
    check("rst_mid_no_b_ack", 32'(bsum), 32'd0);
    access("post_rst_b_read", 1'b1, 1'b0, 8'h41, 8'h00, 1'b0, 8'h22, 1);

    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
